// File: rtl/pe_grid_result_collector.sv
// Buffers result tiles from NUM_PE Winograd PEs in per-PE FIFOs and drains them
// round-robin onto a single output-memory write port, tracking pass completion.
module pe_grid_result_collector #(
    parameter int NUM_PE     = 4,
    parameter int TILE_BITS  = 432,
    parameter int ADDR_W     = 12,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 16,
    localparam int PE_W      = (NUM_PE > 1) ? $clog2(NUM_PE) : 1
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start_i,
    input  logic [CNT_W-1:0]            expected_tiles_i,
    input  logic [NUM_PE-1:0]           res_valid_i,
    input  logic [NUM_PE*TILE_BITS-1:0] res_tile_i,
    input  logic [NUM_PE*ADDR_W-1:0]    res_addr_i,
    output logic                        wr_valid_o,
    input  logic                        wr_ready_i,
    output logic [TILE_BITS-1:0]        wr_tile_o,
    output logic [ADDR_W-1:0]           wr_addr_o,
    output logic [PE_W-1:0]             wr_pe_o,
    output logic [NUM_PE-1:0]           overflow_o,
    output logic                        busy_o,
    output logic                        done_o
);

    localparam int             PTR_W     = $clog2(FIFO_DEPTH);
    localparam logic [PTR_W:0] FILL_FULL = (PTR_W + 1)'(FIFO_DEPTH);
    localparam logic [PTR_W:0] FILL_ONE  = (PTR_W + 1)'(1);
    localparam logic [PTR_W:0] FILL_ZERO = (PTR_W + 1)'(0);
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [TILE_BITS-1:0] tile_mem_r [NUM_PE][FIFO_DEPTH];
    logic [ADDR_W-1:0]    addr_mem_r [NUM_PE][FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr_r   [NUM_PE];
    logic [PTR_W-1:0]     rd_ptr_r   [NUM_PE];
    logic [PTR_W:0]       fill_r     [NUM_PE];
    logic [PE_W-1:0]      rot_idx_s  [NUM_PE];

    logic [NUM_PE-1:0]    empty_s, full_s, push_s, pop_s, drop_s;
    logic                 gnt_valid_s, load_s, handshake_s, count_inc_s;
    logic [PE_W-1:0]      gnt_idx_s, rr_ptr_r;

    logic                 wr_valid_r;
    logic [TILE_BITS-1:0] wr_tile_r;
    logic [ADDR_W-1:0]    wr_addr_r;
    logic [PE_W-1:0]      wr_pe_r;
    logic [NUM_PE-1:0]    overflow_r;
    logic [1:0]           state_r, state_nxt_s;
    logic [CNT_W-1:0]     expected_r, count_r;
    logic                 busy_r, done_r;

    // FIFO status flags and cyclic search order starting at the rr pointer
    always_comb begin
        for (int k = 0; k < NUM_PE; k++) begin
            empty_s[k]   = (fill_r[k] == FILL_ZERO);
            full_s[k]    = (fill_r[k] == FILL_FULL);
            rot_idx_s[k] = PE_W'((int'(rr_ptr_r) + k) % NUM_PE);
        end
    end

    // Round-robin grant: nearest non-empty FIFO at or after the rr pointer wins
    always_comb begin
        gnt_valid_s = |(~empty_s);
        gnt_idx_s   = {PE_W{1'b0}};
        for (int i = NUM_PE - 1; i >= 0; i--) begin
            gnt_idx_s = empty_s[rot_idx_s[i]] ? gnt_idx_s : rot_idx_s[i];
        end
    end

    // Push/pop/drop decisions; a full FIFO still accepts when it pops the same cycle
    always_comb begin
        handshake_s = wr_valid_r & wr_ready_i;
        load_s      = ~wr_valid_r | wr_ready_i;
        for (int k = 0; k < NUM_PE; k++) begin
            pop_s[k]  = load_s && gnt_valid_s && (gnt_idx_s == PE_W'(k)) && !start_i;
            push_s[k] = (state_r == S_RUN) && !start_i && res_valid_i[k] && (!full_s[k] || pop_s[k]);
            drop_s[k] = (state_r == S_RUN) && !start_i && res_valid_i[k] && full_s[k] && !pop_s[k];
        end
    end

    // FIFO storage; payload needs no reset because occupancy is tracked separately
    always_ff @(posedge clk) begin
        for (int k = 0; k < NUM_PE; k++) begin
            if (push_s[k]) begin
                tile_mem_r[k][wr_ptr_r[k]] <= res_tile_i[k*TILE_BITS +: TILE_BITS];
                addr_mem_r[k][wr_ptr_r[k]] <= res_addr_i[k*ADDR_W +: ADDR_W];
            end
        end
    end

    // FIFO pointers and occupancy; start of a pass discards anything buffered
    always_ff @(posedge clk) begin
        if (reset || start_i) begin
            for (int k = 0; k < NUM_PE; k++) begin
                wr_ptr_r[k] <= {PTR_W{1'b0}};
                rd_ptr_r[k] <= {PTR_W{1'b0}};
                fill_r[k]   <= FILL_ZERO;
            end
        end else begin
            for (int k = 0; k < NUM_PE; k++) begin
                if (push_s[k]) wr_ptr_r[k] <= wr_ptr_r[k] + PTR_ONE;
                if (pop_s[k])  rd_ptr_r[k] <= rd_ptr_r[k] + PTR_ONE;
                case ({push_s[k], pop_s[k]})
                    2'b10:   fill_r[k] <= fill_r[k] + FILL_ONE;
                    2'b01:   fill_r[k] <= fill_r[k] - FILL_ONE;
                    default: fill_r[k] <= fill_r[k];
                endcase
            end
        end
    end

    // Output register: holds while stalled, refills from the granted FIFO otherwise
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_valid_r <= 1'b0;
            wr_tile_r  <= {TILE_BITS{1'b0}};
            wr_addr_r  <= {ADDR_W{1'b0}};
            wr_pe_r    <= {PE_W{1'b0}};
            rr_ptr_r   <= {PE_W{1'b0}};
        end else if (start_i) begin
            wr_valid_r <= 1'b0;
        end else if (load_s) begin
            wr_valid_r <= gnt_valid_s;
            if (gnt_valid_s) begin
                wr_tile_r <= tile_mem_r[gnt_idx_s][rd_ptr_r[gnt_idx_s]];
                wr_addr_r <= addr_mem_r[gnt_idx_s][rd_ptr_r[gnt_idx_s]];
                wr_pe_r   <= gnt_idx_s;
                rr_ptr_r  <= (gnt_idx_s == PE_W'(NUM_PE - 1)) ? {PE_W{1'b0}} : gnt_idx_s + PE_W'(1);
            end
        end
    end

    // Pass sequencing; only handshakes inside RUN advance the committed count
    always_comb begin
        state_nxt_s = state_r;
        count_inc_s = 1'b0;
        if (start_i) begin
            state_nxt_s = S_RUN;
        end else begin
            case (state_r)
                S_IDLE: state_nxt_s = S_IDLE;
                S_RUN: begin
                    if (expected_r == {CNT_W{1'b0}}) begin
                        state_nxt_s = S_DONE;
                    end else if (handshake_s && (count_r != expected_r)) begin
                        count_inc_s = 1'b1;
                        state_nxt_s = (count_r + CNT_W'(1) == expected_r) ? S_DONE : S_RUN;
                    end else begin
                        state_nxt_s = S_RUN;
                    end
                end
                S_DONE:  state_nxt_s = S_DONE;
                default: state_nxt_s = S_IDLE;
            endcase
        end
    end

    // State, counters, sticky overflow and registered status flags
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= S_IDLE;
            expected_r <= {CNT_W{1'b0}};
            count_r    <= {CNT_W{1'b0}};
            overflow_r <= {NUM_PE{1'b0}};
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            busy_r  <= (state_nxt_s == S_RUN);
            done_r  <= (state_nxt_s == S_DONE);
            if (start_i) begin
                expected_r <= expected_tiles_i;
                count_r    <= {CNT_W{1'b0}};
                overflow_r <= {NUM_PE{1'b0}};
            end else begin
                if (count_inc_s) count_r <= count_r + CNT_W'(1);
                overflow_r <= overflow_r | drop_s;
            end
        end
    end

    assign wr_valid_o = wr_valid_r;
    assign wr_tile_o  = wr_tile_r;
    assign wr_addr_o  = wr_addr_r;
    assign wr_pe_o    = wr_pe_r;
    assign overflow_o = overflow_r;
    assign busy_o     = busy_r;
    assign done_o     = done_r;

endmodule

// File: tb/tb_pe_grid_result_collector.sv
// Directed bench for pe_grid_result_collector: a per-cycle vector table plus
// hand-written overflow, reset, restart and arbitration sequences.
module tb_pe_grid_result_collector;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [15:0]  expected_tiles;
    logic [3:0]   res_valid;
    logic [1727:0] res_tile;
    logic [47:0]  res_addr;
    logic         wr_ready;
    logic         wr_valid_o;
    logic [431:0] wr_tile_o;
    logic [11:0]  wr_addr_o;
    logic [1:0]   wr_pe_o;
    logic [3:0]   overflow_o;
    logic         busy_o;
    logic         done_o;

    int checks = 0;
    int errors = 0;

    logic [1:0]   hs_pe[$];
    logic [11:0]  hs_addr[$];
    logic [431:0] hs_tile[$];

    typedef struct {
        logic        rst;
        logic        start;
        logic [15:0] exp_n;
        logic [3:0]  vld;
        logic        rdy;
        logic        e_valid;
        logic [1:0]  e_pe;
        logic [7:0]  e_tag;
        logic        e_busy;
        logic        e_done;
        logic [3:0]  e_ovf;
    } vec_t;

    vec_t vecs [21];

    pe_grid_result_collector dut (
        .clk              (clk),
        .reset            (reset),
        .start_i          (start),
        .expected_tiles_i (expected_tiles),
        .res_valid_i      (res_valid),
        .res_tile_i       (res_tile),
        .res_addr_i       (res_addr),
        .wr_valid_o       (wr_valid_o),
        .wr_ready_i       (wr_ready),
        .wr_tile_o        (wr_tile_o),
        .wr_addr_o        (wr_addr_o),
        .wr_pe_o          (wr_pe_o),
        .overflow_o       (overflow_o),
        .busy_o           (busy_o),
        .done_o           (done_o)
    );

    always #5 clk = ~clk;

    function automatic logic [431:0] mk_tile(input logic [7:0] tag, input logic [1:0] pe);
        logic [15:0] w;
        w = {tag, 2'b00, pe, 4'hA};
        return {27{w}};
    endfunction

    function automatic logic [11:0] mk_addr(input logic [7:0] tag, input logic [1:0] pe);
        return {tag, 2'b00, pe};
    endfunction

    task automatic set_data(input logic [7:0] tag);
        for (int k = 0; k < 4; k++) begin
            res_tile[k*432 +: 432] = mk_tile(tag, 2'(k));
            res_addr[k*12 +: 12]   = mk_addr(tag, 2'(k));
        end
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    task automatic chk_tile(input string name, input logic [431:0] act, input logic [431:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    // Handshake is decided by values stable before the coming edge.
    task automatic tick();
        if (wr_valid_o && wr_ready) begin
            hs_pe.push_back(wr_pe_o);
            hs_addr.push_back(wr_addr_o);
            hs_tile.push_back(wr_tile_o);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic clear_hs();
        hs_pe.delete();
        hs_addr.delete();
        hs_tile.delete();
    endtask

    task automatic do_reset();
        reset = 1'b1; start = 1'b0; res_valid = 4'b0000; wr_ready = 1'b0;
        tick(); tick();
        reset = 1'b0;
        clear_hs();
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; expected_tiles = 16'd0; res_valid = 4'b0000;
        wr_ready = 1'b0; res_tile = '0; res_addr = '0;

        //          rst   start  exp     vld      rdy   e_v   pe    tag    busy  done  ovf
        vecs[0]  = '{1'b1, 1'b0, 16'd0, 4'b0000, 1'b0, 1'b0, 2'd0, 8'd0,  1'b0, 1'b0, 4'b0000};
        vecs[1]  = '{1'b0, 1'b1, 16'd4, 4'b0000, 1'b1, 1'b0, 2'd0, 8'd0,  1'b1, 1'b0, 4'b0000};
        vecs[2]  = '{1'b0, 1'b0, 16'd0, 4'b1111, 1'b1, 1'b0, 2'd0, 8'd0,  1'b1, 1'b0, 4'b0000};
        vecs[3]  = '{1'b0, 1'b0, 16'd0, 4'b0000, 1'b1, 1'b1, 2'd0, 8'd2,  1'b1, 1'b0, 4'b0000};
        vecs[4]  = '{1'b0, 1'b0, 16'd0, 4'b0000, 1'b1, 1'b1, 2'd1, 8'd2,  1'b1, 1'b0, 4'b0000};
        vecs[5]  = '{1'b0, 1'b0, 16'd0, 4'b0000, 1'b1, 1'b1, 2'd2, 8'd2,  1'b1, 1'b0, 4'b0000};
        vecs[6]  = '{1'b0, 1'b0, 16'd0, 4'b0000, 1'b1, 1'b1, 2'd3, 8'd2,  1'b1, 1'b0, 4'b0000};
        vecs[7]  = '{1'b0, 1'b0, 16'd0, 4'b0000, 1'b1, 1'b0, 2'd0, 8'd0,  1'b0, 1'b1, 4'b0000};
        vecs[8]  = '{1'b0, 1'b0, 16'd0, 4'b0001, 1'b1, 1'b0, 2'd0, 8'd0,  1'b0, 1'b1, 4'b0000};
        vecs[9]  = '{1'b0, 1'b0, 16'd0, 4'b0000, 1'b1, 1'b0, 2'd0, 8'd0,  1'b0, 1'b1, 4'b0000};
        vecs[10] = '{1'b0, 1'b1, 16'd0, 4'b0000, 1'b1, 1'b0, 2'd0, 8'd0,  1'b1, 1'b0, 4'b0000};
        vecs[11] = '{1'b0, 1'b0, 16'd0, 4'b0000, 1'b1, 1'b0, 2'd0, 8'd0,  1'b0, 1'b1, 4'b0000};
        vecs[12] = '{1'b0, 1'b0, 16'd0, 4'b0000, 1'b1, 1'b0, 2'd0, 8'd0,  1'b0, 1'b1, 4'b0000};
        vecs[13] = '{1'b0, 1'b1, 16'd2, 4'b0000, 1'b1, 1'b0, 2'd0, 8'd0,  1'b1, 1'b0, 4'b0000};
        vecs[14] = '{1'b0, 1'b0, 16'd0, 4'b0100, 1'b0, 1'b0, 2'd0, 8'd0,  1'b1, 1'b0, 4'b0000};
        vecs[15] = '{1'b0, 1'b0, 16'd0, 4'b0000, 1'b0, 1'b1, 2'd2, 8'd14, 1'b1, 1'b0, 4'b0000};
        vecs[16] = '{1'b0, 1'b0, 16'd0, 4'b0000, 1'b0, 1'b1, 2'd2, 8'd14, 1'b1, 1'b0, 4'b0000};
        vecs[17] = '{1'b0, 1'b0, 16'd0, 4'b0000, 1'b1, 1'b0, 2'd0, 8'd0,  1'b1, 1'b0, 4'b0000};
        vecs[18] = '{1'b0, 1'b0, 16'd0, 4'b1000, 1'b1, 1'b0, 2'd0, 8'd0,  1'b1, 1'b0, 4'b0000};
        vecs[19] = '{1'b0, 1'b0, 16'd0, 4'b0000, 1'b1, 1'b1, 2'd3, 8'd18, 1'b1, 1'b0, 4'b0000};
        vecs[20] = '{1'b0, 1'b0, 16'd0, 4'b0000, 1'b1, 1'b0, 2'd0, 8'd0,  1'b0, 1'b1, 4'b0000};

        // Reset state
        tick(); tick();
        chk("rst valid", 64'(wr_valid_o), 64'(0));
        chk_tile("rst tile", wr_tile_o, 432'(0));
        chk("rst addr", 64'(wr_addr_o), 64'(0));
        chk("rst pe", 64'(wr_pe_o), 64'(0));
        chk("rst ovf", 64'(overflow_o), 64'(0));
        chk("rst busy", 64'(busy_o), 64'(0));
        chk("rst done", 64'(done_o), 64'(0));

        // Per-cycle vector table
        for (int r = 0; r < 21; r++) begin
            reset = vecs[r].rst; start = vecs[r].start; expected_tiles = vecs[r].exp_n;
            res_valid = vecs[r].vld; wr_ready = vecs[r].rdy;
            set_data(8'(r));
            tick();
            chk($sformatf("row%0d valid", r), 64'(wr_valid_o), 64'(vecs[r].e_valid));
            chk($sformatf("row%0d busy", r), 64'(busy_o), 64'(vecs[r].e_busy));
            chk($sformatf("row%0d done", r), 64'(done_o), 64'(vecs[r].e_done));
            chk($sformatf("row%0d ovf", r), 64'(overflow_o), 64'(vecs[r].e_ovf));
            if (vecs[r].e_valid) begin
                chk($sformatf("row%0d pe", r), 64'(wr_pe_o), 64'(vecs[r].e_pe));
                chk($sformatf("row%0d addr", r), 64'(wr_addr_o), 64'(mk_addr(vecs[r].e_tag, vecs[r].e_pe)));
                chk_tile($sformatf("row%0d tile", r), wr_tile_o, mk_tile(vecs[r].e_tag, vecs[r].e_pe));
            end
        end
        reset = 1'b0; start = 1'b0; res_valid = 4'b0000;

        // Overflow on PE2 while the write port is stalled for 10 cycles
        do_reset();
        expected_tiles = 16'd20; start = 1'b1; tick(); start = 1'b0;
        wr_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            set_data(8'(8'h30 + i)); res_valid = 4'b0100; tick();
            chk($sformatf("A ovf pulse%0d", i), 64'(overflow_o), (i == 5) ? 64'h4 : 64'h0);
        end
        res_valid = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("A stall valid", 64'(wr_valid_o), 64'(1));
            chk("A stall pe", 64'(wr_pe_o), 64'(2));
            chk("A stall addr", 64'(wr_addr_o), 64'(mk_addr(8'h30, 2'd2)));
            chk_tile("A stall tile", wr_tile_o, mk_tile(8'h30, 2'd2));
        end
        chk("A no hs while stalled", 64'(hs_pe.size()), 64'(0));
        wr_ready = 1'b1;
        for (int i = 0; i < 12; i++) tick();
        chk("A drained count", 64'(hs_pe.size()), 64'(5));
        for (int j = 0; j < hs_pe.size(); j++) begin
            chk($sformatf("A drain%0d pe", j), 64'(hs_pe[j]), 64'(2));
            chk($sformatf("A drain%0d addr", j), 64'(hs_addr[j]), 64'(mk_addr(8'(8'h30 + j), 2'd2)));
        end
        chk("A ovf sticky", 64'(overflow_o), 64'h4);

        // Reset in the middle of RUN with tiles buffered and overflow set
        do_reset();
        expected_tiles = 16'd10; start = 1'b1; tick(); start = 1'b0;
        wr_ready = 1'b0;
        set_data(8'h40); res_valid = 4'b0111; tick();
        res_valid = 4'b0001;
        for (int i = 0; i < 5; i++) begin
            set_data(8'(8'h41 + i)); tick();
        end
        res_valid = 4'b0000;
        chk("B pre ovf", 64'(overflow_o), 64'h1);
        chk("B pre valid", 64'(wr_valid_o), 64'(1));
        reset = 1'b1; tick(); reset = 1'b0;
        chk("B valid", 64'(wr_valid_o), 64'(0));
        chk("B done", 64'(done_o), 64'(0));
        chk("B busy", 64'(busy_o), 64'(0));
        chk("B ovf", 64'(overflow_o), 64'(0));
        clear_hs();
        wr_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            res_valid = (i < 3) ? 4'b1111 : 4'b0000;
            tick();
        end
        res_valid = 4'b0000;
        chk("B no writes after reset", 64'(hs_pe.size()), 64'(0));
        chk("B idle valid", 64'(wr_valid_o), 64'(0));
        chk("B idle ovf", 64'(overflow_o), 64'(0));

        // Restart during RUN discards pending tiles and the count
        do_reset();
        expected_tiles = 16'd3; start = 1'b1; tick(); start = 1'b0;
        wr_ready = 1'b0;
        set_data(8'h50); res_valid = 4'b1111; tick(); res_valid = 4'b0000; tick();
        chk("C pending valid", 64'(wr_valid_o), 64'(1));
        expected_tiles = 16'd2; start = 1'b1; tick(); start = 1'b0;
        chk("C restart valid", 64'(wr_valid_o), 64'(0));
        chk("C restart busy", 64'(busy_o), 64'(1));
        chk("C restart done", 64'(done_o), 64'(0));
        clear_hs();
        wr_ready = 1'b1;
        set_data(8'h60); res_valid = 4'b0010; tick();
        set_data(8'h61); res_valid = 4'b0100; tick();
        res_valid = 4'b0000;
        for (int i = 0; i < 10 && !done_o; i++) tick();
        chk("C done", 64'(done_o), 64'(1));
        chk("C writes at done", 64'(hs_pe.size()), 64'(2));
        if (hs_pe.size() >= 2) begin
            chk("C write0 addr", 64'(hs_addr[0]), 64'(mk_addr(8'h60, 2'd1)));
            chk("C write1 addr", 64'(hs_addr[1]), 64'(mk_addr(8'h61, 2'd2)));
        end
        for (int i = 0; i < 4; i++) tick();
        chk("C no stale writes", 64'(hs_pe.size()), 64'(2));
        chk("C final valid", 64'(wr_valid_o), 64'(0));

        // PE0 and PE3 streaming with wr_ready toggling
        do_reset();
        expected_tiles = 16'd8; start = 1'b1; tick(); start = 1'b0;
        for (int i = 0; i < 40 && hs_pe.size() < 8; i++) begin
            if (i < 4) begin
                set_data(8'(8'h70 + i));
                res_valid = 4'b1001;
            end else begin
                res_valid = 4'b0000;
            end
            wr_ready = (i % 2 == 0) ? 1'b1 : 1'b0;
            tick();
        end
        res_valid = 4'b0000;
        chk("D write count", 64'(hs_pe.size()), 64'(8));
        for (int j = 0; j < hs_pe.size(); j++) begin
            chk($sformatf("D grant%0d pe", j), 64'(hs_pe[j]), (j % 2 == 0) ? 64'(0) : 64'(3));
            chk($sformatf("D grant%0d addr", j), 64'(hs_addr[j]),
                64'(mk_addr(8'(8'h70 + j / 2), (j % 2 == 0) ? 2'd0 : 2'd3)));
        end
        if (hs_tile.size() > 1) chk_tile("D tile1", hs_tile[1], mk_tile(8'h70, 2'd3));
        chk("D ovf", 64'(overflow_o), 64'(0));
        chk("D done", 64'(done_o), 64'(1));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
